// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg : shared RISC-V core types, opcodes and fetch-queue definitions
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LW    = 7'b000_0011;
  localparam logic [6:0] OPC_SW    = 7'b010_0011;
  localparam logic [6:0] OPC_BEQ   = 7'b110_0011;
  localparam logic [6:0] OPC_ALU_R = 7'b011_0011;
  localparam logic [6:0] OPC_ALU_I = 7'b001_0011;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/riscv_fetch_fifo.sv
// ============================================================================
// riscv_fetch_fifo : DEPTH-entry prefetch queue of {pc, instr} with clear
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = AW + 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           clear_i,
  input  logic           push_i,
  input  fetch_entry_t   push_data_i,
  input  logic           pop_i,
  output fetch_entry_t   head_o,
  output logic [CW-1:0]  count_o,
  output logic           empty_o,
  output logic           full_o
);

  fetch_entry_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            w_push;
  logic            w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full queue is legal only when the head leaves the same cycle.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '{pc: RESET_PC, instr: NOP_INSTR};
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_fetch_queue.sv
// ============================================================================
// riscv_fetch_queue : credit-based instruction fetch front end feeding decode
// Optional feature macro: FETCH_BYPASS_EN (0-cycle response-to-decode path)
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_fetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int unsigned     CW         = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     CREDIT_MAX = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic            req_valid_q, req_valid_d;

  logic [CW-1:0]   occ_next;
  logic [CW:0]     credit_sum;
  logic            w_req_fire;
  logic            w_rsp_live;
  logic            w_rsp_dec;
  logic            w_bypass;
  logic            w_push;
  logic            w_pop;

  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_wdata;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;

  assign w_req_fire = req_valid_q && imem_req_ready;
  // Responses are kept only in FETCH and never in a redirect cycle.
  assign w_rsp_live = imem_rsp_valid && (state_q == FETCH) && !redirect_valid;
  assign w_rsp_dec  = imem_rsp_valid && (outstanding_q != '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = w_rsp_live && fifo_empty && id_ready;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop      = id_ready && !fifo_empty;
  assign w_push     = w_rsp_live && !w_bypass && (!fifo_full || w_pop);
  assign fifo_wdata = '{pc: rsp_pc_q, instr: imem_rsp_data};

  riscv_fetch_fifo #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_i     (redirect_valid),
    .push_i      (w_push),
    .push_data_i (fifo_wdata),
    .pop_i       (w_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  always_comb begin
    id_valid = !fifo_empty;
    id_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;
    id_pc    = fifo_head.pc;
`ifdef FETCH_BYPASS_EN
    if (w_bypass) begin
      id_valid = 1'b1;
      id_instr = imem_rsp_data;
      id_pc    = rsp_pc_q;
    end
`endif
  end

  // rsp_pc tracks the PC of the oldest response that will be kept.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    state_d       = state_q;
    outstanding_d = outstanding_q + CW'(w_req_fire) - CW'(w_rsp_dec);

    if (redirect_valid) begin
      fetch_pc_d = align_word(redirect_pc);
      rsp_pc_d   = align_word(redirect_pc);
    end else begin
      if (w_req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (w_rsp_live) rsp_pc_d   = rsp_pc_q + PC_STEP;
    end

    occ_next = redirect_valid ? '0 : (fifo_count + CW'(w_push) - CW'(w_pop));

    if (redirect_valid) begin
      state_d = (outstanding_d != '0) ? FLUSH : FETCH;
    end else if (state_q == FLUSH && outstanding_d == '0) begin
      state_d = FETCH;
    end

    credit_sum  = {1'b0, occ_next} + {1'b0, outstanding_d};
    req_valid_d = (state_d == FETCH) && (credit_sum < CREDIT_MAX);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      req_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      req_valid_q   <= req_valid_d;
    end
  end

endmodule

`default_nettype wire
